// File: rtl/memory_unit.sv
// memory_unit
// 256 x 8 memory shared by a CPU and a program loader.
//
// The CPU side uses an address register (loaded from bus_in) and a write
// strobe; read data is a combinational view of mem[addr_reg]. The loader
// side streams bytes into memory starting at LOAD_BASE, holding the CPU in
// reset for the whole load plus one flush cycle.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset (memory contents survive)
//   bus_in       CPU data bus: address or write data
//   load_add_reg CPU strobe: addr_reg <= bus_in (IDLE only)
//   write        CPU strobe: mem[addr_reg] <= bus_in (IDLE only)
//   data_out     mem[addr_reg], combinational
//   ld_start     one-cycle request to begin a load (IDLE only)
//   ld_valid     loader byte present on ld_data
//   ld_data      loader byte
//   ld_last      marks the final loader byte
//   ld_ready     loader byte is accepted this cycle
//   cpu_hold     CPU must be held in reset
//   ld_count     bytes accepted in the current / most recent load (sat. 256)
//   ld_overflow  sticky: the load wrapped past address 8'hFF

module memory_unit #(
  parameter logic [7:0] LOAD_BASE = 8'd0,
  parameter logic [7:0] MEM_INIT  = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bus_in,
  input  logic       load_add_reg,
  input  logic       write,
  output logic [7:0] data_out,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  input  logic       ld_last,
  output logic       ld_ready,
  output logic       cpu_hold,
  output logic [8:0] ld_count,
  output logic       ld_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Filled once at simulation start; reset deliberately leaves it alone.
  logic [7:0] mem_r [0:255] = '{default: MEM_INIT};

  state_t     state_r;
  state_t     state_next_s;
  logic [7:0] addr_r;
  logic [7:0] addr_next_s;
  logic [7:0] ptr_r;
  logic [7:0] ptr_next_s;
  logic [8:0] count_r;
  logic [8:0] count_next_s;
  logic       ovf_r;
  logic       ovf_next_s;
  logic       ready_r;
  logic       hold_r;

  logic       mem_we_s;
  logic [7:0] mem_waddr_s;
  logic [7:0] mem_wdata_s;

  // Next-state and datapath control for the CPU/loader arbitration FSM.
  always_comb begin
    state_next_s = state_r;
    addr_next_s  = addr_r;
    ptr_next_s   = ptr_r;
    count_next_s = count_r;
    ovf_next_s   = ovf_r;
    mem_we_s     = 1'b0;
    mem_waddr_s  = addr_r;
    mem_wdata_s  = bus_in;

    case (state_r)
      ST_IDLE: begin
        // A same-cycle write uses the old addr_reg because mem_waddr_s is
        // taken from addr_r, while addr_reg updates at the same edge.
        if (write) begin
          mem_we_s = 1'b1;
        end else begin
          mem_we_s = 1'b0;
        end
        if (load_add_reg) begin
          addr_next_s = bus_in;
        end else begin
          addr_next_s = addr_r;
        end
        if (ld_start) begin
          state_next_s = ST_LOAD;
          ptr_next_s   = LOAD_BASE;
          count_next_s = 9'd0;
          ovf_next_s   = 1'b0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (ld_valid) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = ptr_r;
          mem_wdata_s = ld_data;
          ptr_next_s  = ptr_r + 8'd1;
          if (count_r == 9'd256) begin
            count_next_s = count_r;
          end else begin
            count_next_s = count_r + 9'd1;
          end
          if (ld_last) begin
            state_next_s = ST_FLUSH;
          end else if (ptr_r == 8'hFF) begin
            state_next_s = ST_LOAD;
            ovf_next_s   = 1'b1;
          end else begin
            state_next_s = ST_LOAD;
          end
        end else begin
          state_next_s = ST_LOAD;
        end
      end

      ST_FLUSH: begin
        state_next_s = ST_IDLE;
        addr_next_s  = 8'd0;
      end

      default: begin
        state_next_s = ST_IDLE;
        addr_next_s  = 8'd0;
      end
    endcase
  end

  // State, pointer, counters and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      addr_r  <= 8'd0;
      ptr_r   <= LOAD_BASE;
      count_r <= 9'd0;
      ovf_r   <= 1'b0;
      ready_r <= 1'b0;
      hold_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      addr_r  <= addr_next_s;
      ptr_r   <= ptr_next_s;
      count_r <= count_next_s;
      ovf_r   <= ovf_next_s;
      // Decoded from the next state so the outputs leave a flop directly.
      ready_r <= (state_next_s == ST_LOAD);
      hold_r  <= (state_next_s != ST_IDLE);
    end
  end

  // Memory write port; reset blocks writes but never clears contents.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign data_out    = mem_r[addr_r];
  assign ld_ready    = ready_r;
  assign cpu_hold    = hold_r;
  assign ld_count    = count_r;
  assign ld_overflow = ovf_r;

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit: directed scenarios plus randomized
// traffic checked against a behavioural model (array memory, phase flag).
module tb_memory_unit;

  localparam logic [7:0] BASE = 8'h00;
  localparam logic [7:0] INIT = 8'h5A;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bus_in = 8'h00;
  logic       load_add_reg = 1'b0;
  logic       write = 1'b0;
  logic       ld_start = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic       ld_last = 1'b0;

  logic [7:0] data_out, fe_data_out;
  logic       ld_ready, fe_ld_ready;
  logic       cpu_hold, fe_cpu_hold;
  logic [8:0] ld_count, fe_ld_count;
  logic       ld_overflow, fe_ld_overflow;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [7:0] m_mem [256];
  logic [7:0] m_addr;
  logic [7:0] m_ptr;
  logic [8:0] m_count;
  logic       m_ovf;
  int         m_phase; // 0 = cpu owns memory, 1 = loading, 2 = flushing

  always #5 clk = ~clk;

  memory_unit #(.LOAD_BASE(BASE), .MEM_INIT(INIT)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .load_add_reg(load_add_reg),
    .write(write), .data_out(data_out), .ld_start(ld_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .cpu_hold(cpu_hold), .ld_count(ld_count),
    .ld_overflow(ld_overflow)
  );

  memory_unit #(.LOAD_BASE(8'hFE), .MEM_INIT(8'h00)) dut_fe (
    .clk(clk), .rst(rst), .bus_in(bus_in), .load_add_reg(load_add_reg),
    .write(write), .data_out(fe_data_out), .ld_start(ld_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(fe_ld_ready), .cpu_hold(fe_cpu_hold), .ld_count(fe_ld_count),
    .ld_overflow(fe_ld_overflow)
  );

  task automatic model_update();
    if (rst) begin
      m_phase = 0; m_addr = 8'h00; m_ptr = BASE; m_count = 9'd0; m_ovf = 1'b0;
    end else if (m_phase == 0) begin
      if (write) m_mem[m_addr] = bus_in;
      if (load_add_reg) m_addr = bus_in;
      if (ld_start) begin
        m_phase = 1; m_ptr = BASE; m_count = 9'd0; m_ovf = 1'b0;
      end
    end else if (m_phase == 1) begin
      if (ld_valid) begin
        m_mem[m_ptr] = ld_data;
        if (m_count < 9'd256) m_count = m_count + 9'd1;
        if (ld_last) m_phase = 2;
        else if (m_ptr == 8'hFF) m_ovf = 1'b1;
        m_ptr = m_ptr + 8'd1;
      end
    end else begin
      m_phase = 0; m_addr = 8'h00;
    end
  endtask

  // Apply one cycle of inputs, advance the model, sample after the edge.
  task automatic step(input logic r, input logic lar, input logic wr,
                      input logic [7:0] b, input logic st, input logic v,
                      input logic [7:0] d, input logic l);
    rst = r; load_add_reg = lar; write = wr; bus_in = b;
    ld_start = st; ld_valid = v; ld_data = d; ld_last = l;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic set_addr(input logic [7:0] a);
    step(1'b0, 1'b1, 1'b0, a, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 8'hEE, 1'b0);
    checks++;
    if (ld_ready !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++; $display("FAIL reset_hs: ready=%b hold=%b expected 0 0", ld_ready, cpu_hold);
    end
    checks++;
    if (ld_count !== 9'd0 || ld_overflow !== 1'b0) begin
      errors++; $display("FAIL reset_cnt: count=%0d ovf=%b expected 0 0", ld_count, ld_overflow);
    end
    checks++;
    if (data_out !== INIT) begin
      errors++; $display("FAIL reset_data: got %h expected %h", data_out, INIT);
    end
  endtask

  task automatic test_cpu_path();
    set_addr(8'h3C);
    step(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_out !== 8'hA5) begin
      errors++; $display("FAIL cpu_write: got %h expected a5", data_out);
    end
    set_addr(8'h00);
    set_addr(8'h3C);
    checks++;
    if (data_out !== 8'hA5) begin
      errors++; $display("FAIL cpu_reread: got %h expected a5", data_out);
    end
  endtask

  task automatic test_collision();
    logic [7:0] old20;
    set_addr(8'h10);
    old20 = m_mem[8'h20];
    step(1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_out !== old20) begin
      errors++; $display("FAIL collide_new_addr: got %h expected %h", data_out, old20);
    end
    set_addr(8'h10);
    checks++;
    if (data_out !== 8'h20) begin
      errors++; $display("FAIL collide_old_addr: got %h expected 20", data_out);
    end
  endtask

  task automatic test_load();
    logic [7:0] exp_b [3];
    logic       v_seq [7];
    logic [7:0] d_seq [7];
    exp_b = '{8'h71, 8'h92, 8'hD0};
    v_seq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    d_seq = '{8'h00, 8'h71, 8'h33, 8'h44, 8'h92, 8'h55, 8'hD0};
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (cpu_hold !== 1'b1 || ld_ready !== 1'b1) begin
        errors++; $display("FAIL load_hold[%0d]: hold=%b ready=%b expected 1 1", i, cpu_hold, ld_ready);
      end
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, v_seq[i], d_seq[i], (i == 6));
    end
    checks++;
    if (cpu_hold !== 1'b1 || ld_ready !== 1'b0 || ld_count !== 9'd3) begin
      errors++; $display("FAIL load_flush: hold=%b ready=%b count=%0d expected 1 0 3", cpu_hold, ld_ready, ld_count);
    end
    idle();
    checks++;
    if (cpu_hold !== 1'b0 || ld_count !== 9'd3 || data_out !== 8'h71) begin
      errors++; $display("FAIL load_done: hold=%b count=%0d data=%h expected 0 3 71", cpu_hold, ld_count, data_out);
    end
    for (int a = 0; a < 3; a++) begin
      set_addr(8'(a));
      checks++;
      if (data_out !== exp_b[a]) begin
        errors++; $display("FAIL load_mem[%0d]: got %h expected %h", a, data_out, exp_b[a]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_a [3];
    logic [7:0] exp_d [3];
    exp_a = '{8'hFE, 8'hFF, 8'h00};
    exp_d = '{8'h11, 8'h22, 8'h33};
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0);
    checks++;
    if (fe_ld_overflow !== 1'b0) begin
      errors++; $display("FAIL wrap_early_ovf: got %b expected 0", fe_ld_overflow);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b1);
    idle();
    idle();
    checks++;
    if (fe_ld_overflow !== 1'b1 || fe_ld_count !== 9'd3 || fe_cpu_hold !== 1'b0) begin
      errors++; $display("FAIL wrap_flags: ovf=%b count=%0d hold=%b expected 1 3 0", fe_ld_overflow, fe_ld_count, fe_cpu_hold);
    end
    for (int i = 0; i < 3; i++) begin
      set_addr(exp_a[i]);
      checks++;
      if (fe_data_out !== exp_d[i]) begin
        errors++; $display("FAIL wrap_mem[%h]: got %h expected %h", exp_a[i], fe_data_out, exp_d[i]);
      end
    end
  endtask

  task automatic test_lockout();
    set_addr(8'h40);
    step(1'b0, 1'b0, 1'b1, 8'h66, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hC1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 8'h00, 1'b0);
    checks++;
    if (ld_count !== 9'd1 || ld_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      errors++; $display("FAIL lockout_state: count=%0d ready=%b hold=%b expected 1 1 1", ld_count, ld_ready, cpu_hold);
    end
    step(1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 8'hC2, 1'b1);
    idle();
    set_addr(8'h40);
    checks++;
    if (data_out !== 8'h66) begin
      errors++; $display("FAIL lockout_mem40: got %h expected 66", data_out);
    end
    set_addr(8'h77);
    checks++;
    if (data_out !== m_mem[8'h77] || ld_count !== 9'd2) begin
      errors++; $display("FAIL lockout_mem77: data=%h count=%0d expected %h 2", data_out, ld_count, m_mem[8'h77]);
    end
  endtask

  task automatic test_reset_midload();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hAA, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hBB, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hCC, 1'b0);
    checks++;
    if (cpu_hold !== 1'b0 || ld_ready !== 1'b0 || ld_count !== 9'd0) begin
      errors++; $display("FAIL midrst_state: hold=%b ready=%b count=%0d expected 0 0 0", cpu_hold, ld_ready, ld_count);
    end
    idle();
    set_addr(8'h01);
    checks++;
    if (data_out !== 8'hBB) begin
      errors++; $display("FAIL midrst_mem1: got %h expected bb", data_out);
    end
    set_addr(8'h00);
    checks++;
    if (data_out !== 8'hAA) begin
      errors++; $display("FAIL midrst_mem0: got %h expected aa", data_out);
    end
    set_addr(8'h02);
    checks++;
    if (data_out !== m_mem[8'h02]) begin
      errors++; $display("FAIL midrst_mem2: got %h expected %h", data_out, m_mem[8'h02]);
    end
  endtask

  task automatic test_saturate();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'($urandom), 1'b0);
    end
    checks++;
    if (ld_count !== 9'd256 || ld_overflow !== 1'b1 || ld_ready !== 1'b1) begin
      errors++; $display("FAIL saturate: count=%0d ovf=%b ready=%b expected 256 1 1", ld_count, ld_overflow, ld_ready);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5C, 1'b1);
    idle();
    checks++;
    if (ld_count !== 9'd256 || cpu_hold !== 1'b0) begin
      errors++; $display("FAIL saturate_end: count=%0d hold=%b expected 256 0", ld_count, cpu_hold);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
           8'($urandom), ($urandom_range(15) == 0), ($urandom_range(1) == 0),
           8'($urandom), ($urandom_range(7) == 0));
      checks++;
      if (data_out !== m_mem[m_addr] || ld_ready !== (m_phase == 1) ||
          cpu_hold !== (m_phase != 0) || ld_count !== m_count || ld_overflow !== m_ovf) begin
        errors++;
        if (bad < 10)
          $display("FAIL random[%0d]: data=%h ready=%b hold=%b count=%0d ovf=%b expected %h %b %b %0d %b",
                   i, data_out, ld_ready, cpu_hold, ld_count, ld_overflow,
                   m_mem[m_addr], (m_phase == 1), (m_phase != 0), m_count, m_ovf);
        bad++;
      end
    end
  endtask

  task automatic test_sweep();
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int a = 0; a < 256; a++) begin
      set_addr(8'(a));
      checks++;
      if (data_out !== m_mem[a]) begin
        errors++; $display("FAIL sweep[%h]: got %h expected %h", a[7:0], data_out, m_mem[a]);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) m_mem[a] = INIT;
    m_phase = 0; m_addr = 8'h00; m_ptr = BASE; m_count = 9'd0; m_ovf = 1'b0;
    @(negedge clk);
    test_reset();
    test_cpu_path();
    test_collision();
    test_load();
    test_wrap();
    test_lockout();
    test_reset_midload();
    test_saturate();
    test_random();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_unit.md
MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 Parameter LOAD_BASE, default 8'd0, first address written by the program loader.
REQ-002 Parameter MEM_INIT, default 8'd0, value used to fill memory at simulation start (not at reset).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 bus_in  input  8  CPU data bus; address or write data.
REQ-006 load_add_reg  input  1  CPU strobe: latch bus_in into the address register.
REQ-007 write  input  1  CPU strobe: store bus_in at the current address.
REQ-008 data_out  output  8  mem[addr_reg], read data to the CPU bus mux.
REQ-009 ld_start  input  1  one-cycle request to begin a program load.
REQ-010 ld_valid  input  1  loader byte present on ld_data.
REQ-011 ld_data  input  8  loader byte.
REQ-012 ld_last  input  1  qualifies ld_valid; marks the final byte.
REQ-013 ld_ready  output  1  block accepts a loader byte this cycle.
REQ-014 cpu_hold  output  1  hold the CPU in reset while a load is in progress.
REQ-015 ld_count  output  9  bytes accepted in the current or most recent load.
REQ-016 ld_overflow  output  1  sticky flag: the load wrapped past address 8'hFF.

Function
REQ-017 Storage SHALL be 256 x 8; addresses wrap modulo 256.
REQ-018 data_out SHALL be a combinational read of mem[addr_reg], with zero cycles from an addr_reg or memory update to a visible value.
REQ-019 In IDLE, load_add_reg=1 SHALL set addr_reg to bus_in at the next edge.
REQ-020 In IDLE, write=1 SHALL set mem[addr_reg] to bus_in at the next edge; data_out SHALL show the new value from the following cycle.
REQ-021 If load_add_reg and write are both high in the same cycle, the write SHALL use the old addr_reg, and addr_reg SHALL then update.
REQ-022 FSM states SHALL be IDLE, LOAD and FLUSH; the reset state is IDLE.
REQ-023 IDLE -> LOAD on ld_start=1: ptr=LOAD_BASE, ld_count=0, ld_overflow=0.
REQ-024 In LOAD: ld_ready=1 and cpu_hold=1; each cycle with ld_valid=1 SHALL write mem[ptr]=ld_data, ptr+=1 (mod 256), ld_count+=1.
REQ-025 In LOAD, an accepted byte with ld_last=1 SHALL move the FSM to FLUSH.
REQ-026 In LOAD, an accepted byte at ptr=8'hFF without ld_last SHALL wrap ptr to 0, set ld_overflow=1 and stay in LOAD.
REQ-027 ld_count SHALL saturate at 9'd256.
REQ-028 FLUSH SHALL last exactly one cycle with ld_ready=0 and cpu_hold=1, then go to IDLE; addr_reg SHALL be cleared to 0 on that transition.
REQ-029 In LOAD and FLUSH, load_add_reg and write SHALL be ignored.
REQ-030 ld_start SHALL be ignored outside IDLE.
REQ-031 ld_valid while ld_ready=0 SHALL be ignored (no write, no count).
REQ-032 In IDLE: ld_ready=0 and cpu_hold=0.
REQ-033 ld_count and ld_overflow SHALL hold their values in IDLE until the next ld_start.

Reset
REQ-034 rst=1 at an edge SHALL set: state=IDLE, addr_reg=0, ptr=LOAD_BASE, ld_count=0, ld_overflow=0, ld_ready=0, cpu_hold=0.
REQ-035 Reset SHALL NOT clear memory contents.
REQ-036 Reset during LOAD or FLUSH SHALL abort the load; bytes already written SHALL remain in memory.
REQ-037 rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-038 CPU path: load_add_reg with bus_in=8'h3C, then write with bus_in=8'hA5 -> next cycle data_out=8'hA5; addr_reg=8'h3C.
REQ-039 Collision: addr_reg=8'h10, then one cycle with load_add_reg=1, write=1, bus_in=8'h20 -> mem[8'h10]=8'h20, addr_reg=8'h20, mem[8'h20] unchanged.
REQ-040 Load: ld_start, then bytes 8'h71, 8'h92, 8'hD0 (ld_last on the third), with ld_valid gaps -> mem[0..2] hold those bytes, ld_count=3, cpu_hold high from the cycle after ld_start through FLUSH, then low.
REQ-041 Wrap: LOAD_BASE=8'hFE, 3 bytes with ld_last on the third -> written to FE, FF, 00; ld_overflow=1; ld_count=3.
REQ-042 Lockout: write=1 and ld_start=1 during LOAD -> memory at addr_reg unchanged, state unchanged, ld_count unchanged.
REQ-043 Reset mid-load: rst after 2 accepted bytes -> state IDLE, cpu_hold=0, ld_count=0, the 2 bytes still readable via the CPU path.
